imem_loader: RTL

Writes a program image into the writable instruction memory of the LEGv8 single-cycle core. It receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word is written to consecutive instruction memory addresses from 0. The core is held via `cpu_hold` until the image is complete.

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/word_packer.sv | 35 +++
 rtl/imem_loader.sv | 134 +++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction memory loader.
// Ports: none (package). Optional checksum state is compiled in with IMEM_LOADER_CHECKSUM_EN.
// Provides loader_state_t, LEN_MAX (largest legal word count) and BYTES_PER_WORD.
package imem_loader_pkg;

  localparam int LEN_MAX        = 64;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_BYTES,
    S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } loader_state_t;

endpackage

// File: rtl/word_packer.sv
// word_packer: assembles four stream bytes into one little-endian 32-bit word.
// Ports: clk, reset (sync, active-high), clr (restart word), push, byte_data in;
//        word (packed word including the byte being pushed), full (4th byte pushed this cycle) out.
module word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        push,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        full
);

  // Only the first three bytes need storage: the fourth is taken straight
  // from byte_data in the cycle it is pushed, so the caller can register the
  // completed word on the same edge that accepts its last byte.
  logic [23:0] sr;
  logic [1:0]  cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      sr  <= '0;
      cnt <= '0;
    end else if (push) begin
      sr  <= {byte_data, sr[23:8]};
      cnt <= cnt + 2'd1;  // wraps to 0 after the 4th byte
    end
  end

  assign word = {byte_data, sr};
  assign full = push && (cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed byte stream into instruction memory, holding the core until done.
// Ports: clk, reset, start, in_data/in_valid/in_ready (byte stream), we/waddr/wdata (imem write),
//        cpu_hold, done, err. Define IMEM_LOADER_CHECKSUM_EN to add a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int N      = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [N-1:0]      wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  loader_state_t state, next;

  // One bit wider than the address so a full 64-word image ends at 64, not 0.
  logic [ADDR_W:0] len;
  logic [ADDR_W:0] widx;

  logic        xfer;
  logic        push;
  logic        pk_clr;
  logic [31:0] pk_word;
  logic        pk_full;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] chk;
`endif

  assign xfer = in_valid && in_ready;
  assign push = xfer && (state == S_BYTES);

  word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clr       (pk_clr),
    .push      (push),
    .byte_data (in_data),
    .word      (pk_word),
    .full      (pk_full)
  );

  always_comb begin
    next   = state;
    pk_clr = (state == S_LEN);
    case (state)
      S_IDLE: if (start) next = S_LEN;
      S_LEN: begin
        if (xfer) begin
          if (in_data == 8'd0 || in_data > 8'(LEN_MAX)) next = S_ERR;
          else                                          next = S_BYTES;
        end
      end
      S_BYTES: if (pk_full) next = S_WRITE;
      S_WRITE: begin
        // widx was already bumped on entry to WRITE, so it counts words written.
        if (widx == len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          next = S_CHK;
`else
          next = S_DONE;
`endif
        end else begin
          next = S_BYTES;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: if (xfer) next = (in_data == chk) ? S_DONE : S_ERR;
`endif
      S_DONE:  if (start) next = S_LEN;
      S_ERR:   if (start) next = S_LEN;
      default: next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      len      <= '0;
      widx     <= '0;
      in_ready <= 1'b0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk      <= '0;
`endif
    end else begin
      state <= next;

      // Outputs are decoded from the next state so they are registered yet
      // line up with the state they describe.
`ifdef IMEM_LOADER_CHECKSUM_EN
      in_ready <= (next == S_LEN) || (next == S_BYTES) || (next == S_CHK);
`else
      in_ready <= (next == S_LEN) || (next == S_BYTES);
`endif
      we       <= (next == S_WRITE);
      done     <= (next == S_DONE);
      err      <= (next == S_ERR);
      cpu_hold <= (next != S_DONE);

      if (state == S_LEN && xfer) begin
        len  <= in_data[ADDR_W:0];
        widx <= '0;
      end

      if (pk_full) begin
        waddr <= widx[ADDR_W-1:0];
        wdata <= pk_word;
        widx  <= widx + 1'b1;
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      if (state == S_LEN && xfer) chk <= '0;
      else if (push)              chk <= chk ^ in_data;
`endif
    end
  end

endmodule
